// File: rtl/ahb_pkg.sv
// ahb_pkg: shared definitions for the AHB-Lite slave subsystem.
// Holds the AHB encodings (transfer type, size, burst, response, direction),
// the address-region codes decoded from HADDR[31:30], the timer register
// offsets, and a helper that resolves the timer mode from the ctrl bits.
package ahb_pkg;

   localparam int AHB_DATA_WIDTH     = 32;
   localparam int AHB_ADDR_WIDTH     = 32;
   localparam int AHB_REG_FILE_DEPTH = 16;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_t;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_t;

   typedef enum logic {
      HWRITE_READ  = 1'b0,
      HWRITE_WRITE = 1'b1
   } hwrite_t;

   localparam logic [1:0] REGION_REGFILE = 2'b00;
   localparam logic [1:0] REGION_TIMER   = 2'b01;

   localparam logic [29:0] TMR_CTRL      = 30'h00;
   localparam logic [29:0] TMR_LOAD      = 30'h04;
   localparam logic [29:0] TMR_PWM_THRES = 30'h0C;
   localparam logic [29:0] TMR_COUNT     = 30'h10;
   localparam logic [29:0] TMR_STATUS    = 30'h14;

   localparam int TIMER_LOAD_RESET = 32'h0F;

   typedef enum logic [1:0] {
      MODE_OFF,
      MODE_NORMAL,
      MODE_WATCHDOG,
      MODE_PWM
   } timer_mode_t;

   // When several ctrl bits are set the watchdog wins, then PWM, then the
   // plain timer, so a single mode is always active.
   function automatic timer_mode_t timer_mode(input logic [2:0] ctrl_bits);
      if (ctrl_bits[1]) return MODE_WATCHDOG;
      if (ctrl_bits[2]) return MODE_PWM;
      if (ctrl_bits[0]) return MODE_NORMAL;
      return MODE_OFF;
   endfunction

endpackage

// File: rtl/ahb_if.sv
// ahb_if: AHB-Lite bus bundle between the single master and this slave.
// Signals: HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA (master to
// slave) and HREADY, HRESP, HRDATA (slave to master).
// Modports: master drives the request side, slave drives the response side.
interface ahb_if
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH = AHB_DATA_WIDTH,
   parameter int ADDR_WIDTH = AHB_ADDR_WIDTH
);

   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic                  HREADY;
   logic                  HRESP;
   logic [DATA_WIDTH-1:0] HRDATA;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      input  HREADY, HRESP, HRDATA
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      output HREADY, HRESP, HRDATA
   );

endinterface

// File: rtl/ahb_reg_file.sv
// ahb_reg_file: word-addressed register file behind the AHB slave.
// Ports: clk, rst (synchronous active-high), wr_en (commit a write this
// edge), idx (word index shared by read and write), wr_data, rd_data
// (combinational read of memory[idx]).
module ahb_reg_file
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH = AHB_DATA_WIDTH,
   parameter int DEPTH      = AHB_REG_FILE_DEPTH,
   localparam int IDX_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] memory [DEPTH];

   // Reset clears every word; reset also wins over a write that happens to
   // be committing on the same edge, so an interrupted transfer leaves no trace.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            memory[i] <= '0;
         end
      end else if (wr_en) begin
         memory[idx] <= wr_data;
      end
   end

   assign rd_data = memory[idx];

endmodule

// File: rtl/ahb_timer.sv
// ahb_timer: timer block with normal, watchdog and PWM modes.
// Ports: clk, rst (synchronous active-high), wr_en/offset/wr_data (a bus
// write committing this edge), timer_ctrl, timer_load, pwm_thres,
// timer_count, timer_status (register values for the read mux),
// pwm (waveform), wd_rst (one-cycle watchdog expiry pulse).
module ahb_timer
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH = AHB_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [29:0]           offset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] timer_ctrl,
   output logic [DATA_WIDTH-1:0] timer_load,
   output logic [DATA_WIDTH-1:0] pwm_thres,
   output logic [DATA_WIDTH-1:0] timer_count,
   output logic                  timer_status,
   output logic                  pwm,
   output logic                  wd_rst
);

   timer_mode_t mode;

   assign mode = timer_mode(timer_ctrl[2:0]);

   // Register writes and the counter share one block. A ctrl write restarts
   // the count and clears the expired flag, and takes precedence over the
   // mode's own count update that cycle; this is what makes a ctrl rewrite
   // act as the watchdog kick. wd_rst defaults low so it only ever lasts one
   // cycle. Normal mode holds the count at load once it gets there.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_ctrl   <= '0;
         timer_load   <= DATA_WIDTH'(TIMER_LOAD_RESET);
         pwm_thres    <= '0;
         timer_count  <= '0;
         timer_status <= 1'b0;
         wd_rst       <= 1'b0;
      end else begin
         wd_rst <= 1'b0;
         if (wr_en && (offset == TMR_LOAD)) begin
            timer_load <= wr_data;
         end
         if (wr_en && (offset == TMR_PWM_THRES)) begin
            pwm_thres <= wr_data;
         end
         if (wr_en && (offset == TMR_CTRL)) begin
            timer_ctrl   <= wr_data;
            timer_count  <= '0;
            timer_status <= 1'b0;
         end else begin
            case (mode)
               MODE_WATCHDOG: begin
                  if (timer_count == timer_load) begin
                     timer_count <= '0;
                     wd_rst      <= 1'b1;
                  end else begin
                     timer_count <= timer_count + DATA_WIDTH'(1);
                  end
               end
               MODE_PWM: begin
                  if (timer_count == timer_load) begin
                     timer_count <= '0;
                  end else begin
                     timer_count <= timer_count + DATA_WIDTH'(1);
                  end
               end
               MODE_NORMAL: begin
                  if (timer_count == timer_load) begin
                     timer_status <= 1'b1;
                  end else begin
                     timer_count <= timer_count + DATA_WIDTH'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // The waveform follows the count directly, so it is only meaningful while
   // PWM is the winning mode and is forced low otherwise.
   assign pwm = (mode == MODE_PWM) && (timer_count < pwm_thres);

endmodule

// File: rtl/ahb_top.sv
// ahb_top: zero-wait-state AHB-Lite slave subsystem.
// Ports: HCLK (clock), HRESETn (synchronous active-high reset), bus
// (ahb_if slave modport: HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA in,
// HREADY/HRESP/HRDATA out), pwm (timer PWM waveform), wd_rst (watchdog
// expiry pulse).
// HADDR[31:30] selects the register file (00), the timer (01) or nothing
// (10/11, answered with ERROR).
module ahb_top
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH     = AHB_DATA_WIDTH,
   parameter int REG_FILE_DEPTH = AHB_REG_FILE_DEPTH
) (
   input  logic HCLK,
   input  logic HRESETn,
   ahb_if.slave bus,
   output logic pwm,
   output logic wd_rst
);

   localparam int          IDX_W     = $clog2(REG_FILE_DEPTH);
   localparam logic [29:0] REG_LIMIT = 30'(REG_FILE_DEPTH);

   logic                  dp_valid;
   logic                  dp_write;
   logic [1:0]            dp_region;
   logic [29:0]           dp_offset;
   logic                  reg_sel;
   logic                  reg_in_range;
   logic                  tmr_sel;
   logic                  bad_region;
   logic                  reg_wr_en;
   logic                  tmr_wr_en;
   logic [DATA_WIDTH-1:0] reg_rdata;
   logic [DATA_WIDTH-1:0] tmr_rdata;
   logic [DATA_WIDTH-1:0] read_data;
   logic [DATA_WIDTH-1:0] timer_ctrl;
   logic [DATA_WIDTH-1:0] timer_load;
   logic [DATA_WIDTH-1:0] pwm_thres;
   logic [DATA_WIDTH-1:0] timer_count;
   logic                  timer_status;
   logic                  unused_sideband;

   // Size, burst and protection carry no meaning here: every access is a
   // word and bursts are just back-to-back single transfers.
   assign unused_sideband = ^{bus.HSIZE, bus.HBURST, bus.HPROT};

   // Capture the address phase so the next cycle can act as its data phase.
   // IDLE and BUSY register as "no transfer", which leaves a write already in
   // its data phase untouched because that write commits on this same edge.
   always_ff @(posedge HCLK) begin
      if (HRESETn) begin
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_region <= 2'b00;
         dp_offset <= '0;
      end else begin
         dp_valid  <= (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
         dp_write  <= (bus.HWRITE == HWRITE_WRITE);
         dp_region <= bus.HADDR[31:30];
         dp_offset <= bus.HADDR[29:0];
      end
   end

   assign reg_sel      = dp_valid && (dp_region == REGION_REGFILE);
   assign reg_in_range = (dp_offset < REG_LIMIT);
   assign tmr_sel      = dp_valid && (dp_region == REGION_TIMER);
   assign bad_region   = dp_valid && dp_region[1];
   assign reg_wr_en    = reg_sel && reg_in_range && dp_write;
   assign tmr_wr_en    = tmr_sel && dp_write;

   ahb_reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (REG_FILE_DEPTH)
   ) reg_file (
      .clk     (HCLK),
      .rst     (HRESETn),
      .wr_en   (reg_wr_en),
      .idx     (dp_offset[IDX_W-1:0]),
      .wr_data (bus.HWDATA),
      .rd_data (reg_rdata)
   );

   ahb_timer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) timer (
      .clk          (HCLK),
      .rst          (HRESETn),
      .wr_en        (tmr_wr_en),
      .offset       (dp_offset),
      .wr_data      (bus.HWDATA),
      .timer_ctrl   (timer_ctrl),
      .timer_load   (timer_load),
      .pwm_thres    (pwm_thres),
      .timer_count  (timer_count),
      .timer_status (timer_status),
      .pwm          (pwm),
      .wd_rst       (wd_rst)
   );

   // Timer register view; offsets with no register behind them read as zero
   // but still complete with OKAY.
   always_comb begin
      tmr_rdata = '0;
      case (dp_offset)
         TMR_CTRL:      tmr_rdata = timer_ctrl;
         TMR_LOAD:      tmr_rdata = timer_load;
         TMR_PWM_THRES: tmr_rdata = pwm_thres;
         TMR_COUNT:     tmr_rdata = timer_count;
         TMR_STATUS:    tmr_rdata = {{(DATA_WIDTH-1){1'b0}}, timer_status};
         default:       tmr_rdata = '0;
      endcase
   end

   // Read data is driven only for a read in its data phase that hit a real
   // target; errors, writes and idle cycles all present zero.
   always_comb begin
      read_data = '0;
      if (dp_valid && !dp_write) begin
         if (reg_sel && reg_in_range) begin
            read_data = reg_rdata;
         end else if (tmr_sel) begin
            read_data = tmr_rdata;
         end
      end
   end

   assign bus.HRDATA = read_data;
   assign bus.HRESP  = ((reg_sel && !reg_in_range) || bad_region) ? HRESP_ERROR : HRESP_OKAY;
   assign bus.HREADY = 1'b1;

endmodule

// File: tb/tb_ahb_top.sv
// tb_ahb_top: self-checking bench for ahb_top.
// Drives AHB transfers one per cycle, predicts each data-phase response from
// a transaction-level model of the memory map, and checks the timer outputs
// against closed-form expectations derived from load/threshold values.
module tb_ahb_top;
   import ahb_pkg::*;

   localparam logic [31:0] T_CTRL   = 32'h4000_0000;
   localparam logic [31:0] T_LOAD   = 32'h4000_0004;
   localparam logic [31:0] T_THRES  = 32'h4000_000C;
   localparam logic [31:0] T_COUNT  = 32'h4000_0010;
   localparam logic [31:0] T_STATUS = 32'h4000_0014;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b1;
   logic pwm;
   logic wd_rst;

   ahb_if bus ();

   ahb_top dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus),
      .pwm     (pwm),
      .wd_rst  (wd_rst)
   );

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int fails  = 0;

   logic [31:0] model_mem [16];
   logic [31:0] model_ctrl;
   logic [31:0] model_load;
   logic [31:0] model_thres;

   logic        pend_valid = 1'b0;
   logic        pend_write = 1'b0;
   logic [31:0] pend_addr  = '0;
   logic [31:0] pend_wdata = '0;

   logic [31:0] obs_rdata;
   logic        obs_wd;
   logic        obs_pwm;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      model_ctrl  = '0;
      model_load  = 32'h0F;
      model_thres = '0;
   endtask

   // Predict and check the data phase of the transfer issued last cycle,
   // updating the model when it is a write that lands.
   task automatic checkDataPhase();
      logic [1:0]  region;
      logic [29:0] off;
      logic [31:0] exp_resp;
      logic [31:0] exp_data;
      bit          check_data;
      region     = pend_addr[31:30];
      off        = pend_addr[29:0];
      exp_resp   = 0;
      exp_data   = 0;
      check_data = 1;
      if (region >= 2) begin
         exp_resp = 1;
      end else if (region == 0) begin
         if (off >= 16) exp_resp = 1;
         else if (pend_write) model_mem[off[3:0]] = pend_wdata;
         else exp_data = model_mem[off[3:0]];
      end else begin
         if (pend_write) begin
            if (off == 30'h00) model_ctrl = pend_wdata;
            if (off == 30'h04) model_load = pend_wdata;
            if (off == 30'h0C) model_thres = pend_wdata;
         end else begin
            case (off)
               30'h00:          exp_data = model_ctrl;
               30'h04:          exp_data = model_load;
               30'h0C:          exp_data = model_thres;
               30'h10, 30'h14:  check_data = 0;
               default:         exp_data = 0;
            endcase
         end
      end
      checkOutput("hresp", {31'b0, bus.HRESP}, exp_resp);
      if (!pend_write && check_data) checkOutput("hrdata", bus.HRDATA, exp_data);
   endtask

   // One bus cycle: present a new address phase plus the write data of the
   // transfer now in its data phase, then check that data phase mid-cycle.
   task automatic applyStimulus(input logic [1:0] trans, input logic write, input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge HCLK);
      #1;
      bus.HTRANS = trans;
      bus.HWRITE = write;
      bus.HADDR  = addr;
      bus.HSIZE  = 3'($urandom_range(0, 2));
      bus.HBURST = 3'($urandom_range(0, 7));
      bus.HPROT  = 4'($urandom_range(0, 15));
      bus.HWDATA = pend_write ? pend_wdata : $urandom;
      @(negedge HCLK);
      obs_rdata = bus.HRDATA;
      obs_wd    = wd_rst;
      obs_pwm   = pwm;
      if (pend_valid) begin
         checkDataPhase();
      end else begin
         checkOutput("idle_hresp", {31'b0, bus.HRESP}, 0);
         checkOutput("idle_hready", {31'b0, bus.HREADY}, 1);
      end
      pend_valid = (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
      pend_write = write;
      pend_addr  = addr;
      pend_wdata = wdata;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(HTRANS_IDLE, 1'b0, 32'h0, $urandom);
   endtask

   // Single write followed by its data phase; the next call samples the
   // first cycle after the write has committed.
   task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(HTRANS_NONSEQ, 1'b1, addr, data);
      idle(1);
   endtask

   task automatic readReg(input logic [31:0] addr);
      applyStimulus(HTRANS_NONSEQ, 1'b0, addr, $urandom);
      idle(1);
   endtask

   task automatic doReset();
      @(posedge HCLK);
      #1;
      HRESETn    = 1'b1;
      bus.HTRANS = HTRANS_IDLE;
      bus.HWDATA = pend_wdata;
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn    = 1'b0;
      pend_valid = 1'b0;
      pend_write = 1'b0;
      modelReset();
   endtask

   initial begin
      int          load_v;
      int          thres_v;
      int          highs;
      int          pulses;
      int          nt;
      int          r;
      logic [1:0]  trans;
      logic [31:0] addr;

      bus.HADDR  = '0;
      bus.HTRANS = HTRANS_IDLE;
      bus.HWRITE = 1'b0;
      bus.HSIZE  = HSIZE_WORD;
      bus.HBURST = HBURST_SINGLE;
      bus.HPROT  = '0;
      bus.HWDATA = '0;
      modelReset();

      doReset();
      @(negedge HCLK);
      checkOutput("rst_hrdata", bus.HRDATA, 0);
      checkOutput("rst_hresp", {31'b0, bus.HRESP}, 0);
      checkOutput("rst_hready", {31'b0, bus.HREADY}, 1);
      checkOutput("rst_pwm", {31'b0, pwm}, 0);
      checkOutput("rst_wd", {31'b0, wd_rst}, 0);
      readReg(T_LOAD);
      readReg(T_COUNT);
      checkOutput("rst_count", obs_rdata, 0);
      readReg(T_STATUS);
      checkOutput("rst_status", obs_rdata, 0);
      readReg(32'h5);

      $display("[TB] directed register file transfers");
      applyStimulus(HTRANS_NONSEQ, 1'b1, 32'h0, 32'h0A);
      applyStimulus(HTRANS_NONSEQ, 1'b0, 32'h0, 32'h0);
      idle(1);
      checkOutput("mem0_readback", obs_rdata, 32'h0A);
      writeReg(32'h20, 32'h0B);
      readReg(32'h20);
      for (int i = 1; i <= 4; i++) begin
         logic [31:0] dvals [4];
         dvals = '{32'h23, 32'h12, 32'h34, 32'h56};
         applyStimulus(HTRANS_NONSEQ, 1'b1, 32'(i), dvals[i-1]);
      end
      for (int i = 1; i <= 4; i++) applyStimulus(HTRANS_NONSEQ, 1'b0, 32'(i), 0);
      idle(1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 32'(4 * i), 32'(i + 1));
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, 32'(4 * i), 0);
      end
      idle(1);
      checkOutput("incr4_mem12", obs_rdata, 4);
      applyStimulus(HTRANS_NONSEQ, 1'b1, 32'h0F, 32'h04);
      applyStimulus(HTRANS_BUSY, 1'b0, 32'h10, 0);
      readReg(32'h0F);
      checkOutput("busy_mem15", obs_rdata, 32'h04);
      writeReg(32'h8000_000C, 32'hDEAD);
      readReg(32'hC000_0010);

      $display("[TB] reset in the middle of a write");
      writeReg(32'h3, 32'h77);
      applyStimulus(HTRANS_NONSEQ, 1'b1, 32'h3, 32'h55);
      doReset();
      readReg(32'h3);
      checkOutput("mid_reset_mem3", obs_rdata, 0);

      $display("[TB] normal timer");
      load_v = 5;
      writeReg(T_LOAD, 32'(load_v));
      writeReg(T_CTRL, 32'h1);
      for (int k = 0; k < 16; k++) begin
         applyStimulus(HTRANS_NONSEQ, 1'b0, T_STATUS, 0);
         if (k >= 1) checkOutput("status_t", obs_rdata, (k >= load_v + 1) ? 1 : 0);
      end
      idle(1);
      readReg(T_COUNT);
      checkOutput("count_hold", obs_rdata, 32'(load_v));

      $display("[TB] watchdog");
      load_v = $urandom_range(4, 9);
      writeReg(T_LOAD, 32'(load_v));
      for (int i = 0; i < 6; i++) begin
         idle(2);
         checkOutput("wd_kicked", {31'b0, obs_wd}, 0);
         writeReg(T_CTRL, 32'h2);
         checkOutput("wd_kicked", {31'b0, obs_wd}, 0);
      end
      pulses = 0;
      nt = 3 * (load_v + 1) + 1;
      for (int t = 0; t < nt; t++) begin
         idle(1);
         checkOutput("wd_t", {31'b0, obs_wd}, (t != 0 && (t % (load_v + 1)) == 0) ? 1 : 0);
         if (obs_wd) pulses++;
      end
      checkOutput("wd_pulses", 32'(pulses), 3);

      $display("[TB] pwm");
      doReset();
      writeReg(T_THRES, 32'h2);
      writeReg(T_CTRL, 32'h4);
      highs = 0;
      for (int t = 0; t < 48; t++) begin
         idle(1);
         checkOutput("pwm_t", {31'b0, obs_pwm}, ((t % 16) < 2) ? 1 : 0);
         if (obs_pwm) highs++;
      end
      checkOutput("pwm_highs", 32'(highs), 6);
      load_v  = $urandom_range(3, 12);
      thres_v = $urandom_range(0, load_v + 1);
      writeReg(T_LOAD, 32'(load_v));
      writeReg(T_THRES, 32'(thres_v));
      writeReg(T_CTRL, 32'h4);
      highs = 0;
      for (int t = 0; t < 3 * (load_v + 1); t++) begin
         idle(1);
         checkOutput("pwm_rand_t", {31'b0, obs_pwm}, ((t % (load_v + 1)) < thres_v) ? 1 : 0);
         if (obs_pwm) highs++;
      end
      checkOutput("pwm_rand_highs", 32'(highs), 32'(3 * thres_v));

      $display("[TB] mode priority");
      writeReg(T_CTRL, 32'h6);
      for (int t = 0; t <= load_v + 1; t++) begin
         idle(1);
         checkOutput("prio_pwm", {31'b0, obs_pwm}, 0);
         checkOutput("prio_wd", {31'b0, obs_wd}, (t == load_v + 1) ? 1 : 0);
      end

      $display("[TB] random transfers");
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) trans = HTRANS_IDLE;
         else if (r < 3) trans = HTRANS_BUSY;
         else if (r < 7) trans = HTRANS_NONSEQ;
         else trans = HTRANS_SEQ;
         r = $urandom_range(0, 9);
         if (r < 7) begin
            addr = {2'b00, 30'($urandom_range(0, 19))};
         end else if (r < 9) begin
            r = $urandom_range(0, 2);
            addr = (r == 0) ? T_LOAD : (r == 1) ? T_THRES : 32'h4000_0008;
         end else begin
            addr = {1'b1, 31'($urandom)};
         end
         applyStimulus(trans, 1'($urandom_range(0, 1)), addr, $urandom);
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/ahb_top.md
Name: ahb_top

Overview:
- AHB-Lite slave subsystem with zero wait states.
- It decodes each AHB transfer by HADDR[31:30]:
  - 00: a 16-word register file.
  - 01: a timer block with three modes (normal timer, watchdog, PWM).
  - 10 and 11: unmapped; the transfer receives an ERROR response.
- It sits behind a single AHB master. It produces pwm and wd_rst outputs for the rest of the system.

Parameters:
- DATA_WIDTH, 32, width of HWDATA, HRDATA and the registers.
- ADDR_WIDTH, 32, width of HADDR.
- REG_FILE_DEPTH, 16, number of words in the register file.

Ports:
- HCLK  in  1  the single clock; all logic updates on the rising edge.
- HRESETn  in  1  synchronous, active-high reset: a 1 sampled on the HCLK rising edge resets the block.
- HADDR  in  ADDR_WIDTH  address-phase address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size; only WORD (010) is supported.
- HBURST  in  3  burst type; accepted but not used.
- HPROT  in  4  protection bits; ignored.
- HWDATA  in  DATA_WIDTH  write data, driven in the data phase.
- HREADY  out  1  always 1 (no wait states).
- HRESP  out  1  0 = OKAY, 1 = ERROR; valid in the data phase.
- HRDATA  out  DATA_WIDTH  read data; valid in the data phase.
- pwm  out  1  PWM waveform.
- wd_rst  out  1  watchdog expiry pulse.

Behaviour:
- Reset values:
  - HRDATA = 0, HRESP = 0, HREADY = 1, pwm = 0, wd_rst = 0.
  - Register file = all 0.
  - timer_ctrl = 0, timer_load = 0x0F, pwm_thres = 0, count = 0, status = 0.
- Pipeline:
  - A transfer is valid when HTRANS is NONSEQ or SEQ.
  - On each rising edge, register the address phase: valid, HWRITE, HADDR, region.
  - The following cycle is the data phase. Writes commit HWDATA at the end of the data phase.
  - Reads drive HRDATA combinationally from the registered address during the data phase.
  - Back-to-back transfers (consecutive NONSEQ, or INCR4 NONSEQ then SEQ) are fully pipelined, one transfer per cycle.
- IDLE/BUSY:
  - No access is performed and HRESP = 0.
  - A BUSY cycle between phases does not corrupt the pending data-phase write.
- Register file (region 00):
  - Word index = HADDR[29:0] used directly; byte addresses 0, 4, 8 and 12 map to memory[0], [4], [8] and [12].
  - An index >= REG_FILE_DEPTH gives HRESP = 1 in the data phase, no write, and HRDATA = 0.
- Timer (region 01), register offsets in HADDR[29:0]:
  - 0x00 ctrl (RW): bit0 = normal, bit1 = watchdog, bit2 = pwm. Writing ctrl clears count and status.
  - 0x04 load (RW).
  - 0x0C pwm_thres (RW).
  - 0x10 count (RO).
  - 0x14 status (RO): bit0 = expired, other bits 0.
  - Any other offset returns 0 with OKAY. Writes to RO registers are ignored.
- Normal mode (bit0 set):
  - count increments each cycle.
  - When count == load, status is set to 1 and count holds.
  - status is sticky until ctrl is written or reset is applied.
- Watchdog mode (bit1 set):
  - count increments each cycle.
  - When count == load, wd_rst pulses high for one cycle and count restarts at 0.
  - Rewriting ctrl restarts the count (the "kick").
- PWM mode (bit2 set):
  - count wraps from load back to 0.
  - pwm = 1 while count < pwm_thres, else 0.
  - pwm = 0 when PWM mode is off.
- Multiple ctrl bits set: priority is watchdog > pwm > normal.
- Region 10/11: HRESP = 1 in the data phase, writes dropped, HRDATA = 0.
- Reset asserted mid-transfer aborts the transfer and clears all state.
- HSIZE other than WORD is treated as WORD.

Decomposition:
- Package ahb_pkg holds:
  - enums for htrans, hsize, hburst, hresp (OKAY/ERROR) and hwrite (READ/WRITE);
  - region codes;
  - timer offsets.
- Sub-modules:
  - ahb_reg_file, instance name reg_file, array named memory.
  - ahb_timer, instance name timer, status signal named timer_status.
- Top level holds the address-phase registers, the decoder and the read mux.

Test Plan:
- Write 0x0A to 0x00, then read 0x00 → memory[0] = 0x0A; data-phase HRDATA = 0x0A with HRESP = 0.
- Write 0x0B to 0x20 → HRESP = 1 in the data phase; no memory change.
- Consecutive NONSEQ writes of 0x23, 0x12, 0x34, 0x56 to addresses 1, 2, 3, 4 → each memory word matches, HRESP = 0 throughout.
- INCR4 at base 0 with data 1, 2, 3, 4 → memory[0], [4], [8], [12] = 1, 2, 3, 4.
- NONSEQ write to 0x0F followed by a BUSY cycle → memory[15] = 0x04.
- Timer sequence:
  - ctrl = 1, load = 5 → status bit0 rises after 5 counts; reading 0x14 returns bit0 = 1.
  - ctrl = 2 → wd_rst pulses once.
  - Reset, pwm_thres = 2, ctrl = 4 → pwm is high 2 of every 16 cycles.
- Write to {2'b10, 0x0C} → HRESP = 1.
